// File: rtl/jtdd_snd_pkg.sv
// Shared definitions for the Double Dragon sound subsystem: register map
// of the ADPCM channel controllers, their FSM states and the page size.
package jtdd_snd_pkg;

    // Register indices decoded from the sound CPU address bus
    localparam logic [1:0] REG_STOP  = 2'd0;
    localparam logic [1:0] REG_START = 2'd1;
    localparam logic [1:0] REG_END   = 2'd2;
    localparam logic [1:0] REG_GO    = 2'd3;

    // A page is 512 bytes, so a page number is the byte address shifted by 9
    localparam int PAGE_BITS = 9;

    // Playback sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } adpcm_state_e;

endpackage

// File: rtl/jtdd_adpcm_ctrl.sv
// One ADPCM playback channel: the sound CPU programs a start and end page
// and triggers playback; bytes are fetched through the jtframe_rom slot
// handshake and split into nibbles for the MSM5205, high nibble first, one
// nibble per sample strobe. Busy and a sticky underrun flag report back.
module jtdd_adpcm_ctrl
    import jtdd_snd_pkg::*;
#(
    parameter int AW = 16,
    parameter int PW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_wr,
    input  logic [1:0]    cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          vclk_cen,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    adpcm_din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          underrun
);

    localparam logic [PW-1:0] PAGE_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    adpcm_state_e  state_q;
    logic [PW-1:0] start_pg_q;
    logic [PW-1:0] end_pg_q;
    logic [AW-1:0] cnt_q;
    logic [7:0]    buf_q;
    logic          first_q;

    logic          reg_wr;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          unused_din;

    assign reg_wr     = cpu_cen & cpu_wr;
    assign start_addr = {start_pg_q, {PAGE_BITS{1'b0}}};
    // One page past the end page, wrapping naturally at the top of the region
    assign end_addr   = {end_pg_q + PAGE_ONE, {PAGE_BITS{1'b0}}};
    assign unused_din = ^cpu_din[7:PW];

    // Page registers; they only feed the next go or the next end comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_pg_q <= '0;
            end_pg_q   <= '0;
        end else if (reg_wr) begin
            if (cpu_addr == REG_START) start_pg_q <= cpu_din[PW-1:0];
            if (cpu_addr == REG_END)   end_pg_q   <= cpu_din[PW-1:0];
        end
    end

    // Playback sequencer with registered ROM and MSM5205 outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            first_q   <= 1'b0;
            rom_cs    <= 1'b0;
            rom_addr  <= '0;
            adpcm_din <= '0;
            adpcm_rst <= 1'b1;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else if (reg_wr && cpu_addr == REG_GO) begin
            state_q   <= FETCH;
            cnt_q     <= start_addr;
            rom_addr  <= start_addr;
            rom_cs    <= 1'b1;
            first_q   <= 1'b1;
            underrun  <= 1'b0;
            busy      <= 1'b1;
            adpcm_rst <= 1'b0;
        end else if (reg_wr && cpu_addr == REG_STOP) begin
            state_q   <= IDLE;
            rom_cs    <= 1'b0;
            busy      <= 1'b0;
            adpcm_rst <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    rom_cs <= 1'b0;
                end
                FETCH: begin
                    rom_cs   <= 1'b1;
                    rom_addr <= cnt_q;
                    if (vclk_cen) underrun <= 1'b1;
                    if (first_q) begin
                        // The slot may still show ok from its previous client
                        first_q <= 1'b0;
                    end else if (rom_ok) begin
                        buf_q   <= rom_data;
                        rom_cs  <= 1'b0;
                        cnt_q   <= cnt_q + ADDR_ONE;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (vclk_cen) begin
                        adpcm_din <= buf_q[7:4];
                        state_q   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (vclk_cen) begin
                        adpcm_din <= buf_q[3:0];
                        if (cnt_q == end_addr) begin
                            state_q   <= IDLE;
                            busy      <= 1'b0;
                            adpcm_rst <= 1'b1;
                        end else begin
                            state_q  <= FETCH;
                            rom_cs   <= 1'b1;
                            rom_addr <= cnt_q;
                            first_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_adpcm_ctrl.sv
// Self-checking bench for jtdd_adpcm_ctrl. A behavioural model works out,
// from page numbers and a ROM image, the byte addresses and nibble stream a
// playback must produce; a monitor pops expected nibbles whenever a sample
// strobe should yield one and checks the status outputs every cycle.
module tb_jtdd_adpcm_ctrl;
    import jtdd_snd_pkg::*;

    localparam int AW = 16;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cen;
    logic          cpu_wr;
    logic [1:0]    cpu_addr;
    logic [7:0]    cpu_din;
    logic          vclk_cen;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic [3:0]    adpcm_din;
    logic          adpcm_rst;
    logic          busy;
    logic          underrun;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    // Stimulus knobs shared by the driver and the background generators
    int vclkPeriod = 8;
    int vclkJitter = 0;
    int romLatMin  = 3;
    int romLatMax  = 3;
    bit staleOk    = 1'b0;

    // Reference model state
    logic [AW-1:0] addrQ[$];
    logic [3:0]    nibQ[$];
    logic [PW-1:0] mStart, mEnd;
    bit            playing, expBusy, expCs, expUnd, nibDue;
    int            pending, age, nibLeft;
    int            nibEmitted = 0;

    always #5 clk = ~clk;

    jtdd_adpcm_ctrl #(.AW(AW), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cen   (cpu_cen),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .vclk_cen  (vclk_cen),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .adpcm_din (adpcm_din),
        .adpcm_rst (adpcm_rst),
        .busy      (busy),
        .underrun  (underrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One CPU register write; cpu_wr is held a few cycles without cpu_cen first
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        int pre;
        pre = $urandom_range(0, 2);
        @(posedge clk); #1;
        cpu_addr = a;
        cpu_din  = d;
        cpu_wr   = 1'b1;
        cpu_cen  = 1'b0;
        repeat (pre) begin
            @(posedge clk); #1;
        end
        cpu_cen = 1'b1;
        @(posedge clk); #1;
        cpu_cen  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 2'($urandom);
        cpu_din  = 8'($urandom);
    endtask

    task automatic waitPlayEnd(input int maxCycles);
        int i;
        i = 0;
        while (playing && i < maxCycles) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk); #2;
        checkOutput("end_busy", busy, 0);
        checkOutput("end_adpcm_rst", adpcm_rst, 1);
        checkOutput("end_rom_cs", rom_cs, 0);
    endtask

    task automatic waitNibbles(input int n, input int maxCycles);
        int target, i;
        target = nibEmitted + n;
        i = 0;
        while (nibEmitted < target && i < maxCycles) begin
            @(posedge clk);
            i++;
        end
        checkOutput("nibble_wait", nibEmitted >= target, 1);
    endtask

    // Builds the expected address list and nibble stream for a go
    function automatic void startPlay();
        int d, nbytes;
        logic [AW-1:0] a;
        d      = (int'(mEnd) - int'(mStart) + (1 << PW)) % (1 << PW);
        nbytes = (d + 1) * 512;
        addrQ.delete();
        nibQ.delete();
        a = {mStart, 9'b0};
        for (int i = 0; i < nbytes; i++) begin
            addrQ.push_back(a);
            nibQ.push_back(mem[a][7:4]);
            nibQ.push_back(mem[a][3:0]);
            a++;
        end
        playing = 1'b1;
        pending = 0;
        age     = 0;
        nibLeft = 2 * nbytes;
        expBusy = 1'b1;
        expCs   = 1'b1;
        expUnd  = 1'b0;
    endfunction

    // Sample strobe generator
    initial begin
        int vcnt, vtarget;
        vcnt     = 0;
        vtarget  = 8;
        vclk_cen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (vcnt + 1 >= vtarget) begin
                vclk_cen = 1'b1;
                vcnt     = 0;
                vtarget  = vclkPeriod + $urandom_range(0, vclkJitter);
            end else begin
                vclk_cen = 1'b0;
                vcnt++;
            end
        end
    end

    // ROM slot: ok after a latency, garbage data in a request's first cycle
    initial begin
        int rage, lat;
        logic [AW-1:0] prevAddr;
        rage     = 0;
        lat      = 1;
        prevAddr = '0;
        rom_ok   = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst || !rom_cs) begin
                rage     = 0;
                rom_ok   = staleOk;
                rom_data = 8'h3C;
            end else begin
                if (rom_addr != prevAddr) rage = 0;
                if (rage == 0) lat = $urandom_range(romLatMin, romLatMax);
                rage++;
                rom_ok   = staleOk || (rage > lat);
                rom_data = (rage == 1) ? ~mem[rom_addr] : mem[rom_addr];
            end
            prevAddr = rom_addr;
        end
    end

    // Reference model: decides what the coming clock edge must do
    always @(negedge clk) begin
        int p0;
        if (rst) begin
            playing = 1'b0; pending = 0; age = 0; nibLeft = 0;
            addrQ.delete(); nibQ.delete();
            mStart = '0; mEnd = '0;
            expBusy = 1'b0; expCs = 1'b0; expUnd = 1'b0; nibDue = 1'b0;
        end else begin
            nibDue = 1'b0;
            if (cpu_cen && cpu_wr) begin
                case (cpu_addr)
                    REG_STOP: begin
                        playing = 1'b0; pending = 0;
                        expBusy = 1'b0; expCs = 1'b0;
                        addrQ.delete(); nibQ.delete();
                    end
                    REG_START: mStart = cpu_din[PW-1:0];
                    REG_END:   mEnd   = cpu_din[PW-1:0];
                    default:   startPlay();
                endcase
            end else if (playing) begin
                p0 = pending;
                if (vclk_cen) begin
                    if (p0 > 0) begin
                        nibDue = 1'b1;
                        pending--;
                        nibLeft--;
                        nibEmitted++;
                        if (nibLeft == 0) begin
                            playing = 1'b0;
                            expBusy = 1'b0;
                        end
                    end else begin
                        expUnd = 1'b1;
                    end
                end
                if (p0 == 0) begin
                    if (age >= 1 && rom_ok) begin
                        if (addrQ.size() == 0) checkOutput("addr_queue_depth", addrQ.size(), 1);
                        else checkOutput("fetch_addr", rom_addr, addrQ.pop_front());
                        pending = 2;
                        age     = 0;
                    end else begin
                        age++;
                    end
                end
                expCs = playing && (pending == 0);
            end
        end
    end

    // Monitor: pops a nibble when one is due and checks every output
    initial begin
        logic [3:0] expDin;
        expDin = 4'h0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                expDin = 4'h0;
            end else begin
                if (nibDue) begin
                    if (nibQ.size() == 0) checkOutput("nib_queue_depth", nibQ.size(), 1);
                    else expDin = nibQ.pop_front();
                end
                checkOutput("adpcm_din", adpcm_din, expDin);
                checkOutput("busy", busy, expBusy);
                checkOutput("adpcm_rst", adpcm_rst, !expBusy);
                checkOutput("rom_cs", rom_cs, expCs);
                checkOutput("underrun", underrun, expUnd);
                if (expCs && addrQ.size() > 0) checkOutput("rom_addr", rom_addr, addrQ[0]);
            end
        end
    end

    // Watchdog so the bench always ends on its own
    initial begin
        #900000;
        fails++;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Scenario driver
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[16'h0400] = 8'hA5;
        cpu_cen = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rom_cs", rom_cs, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_adpcm_din", adpcm_din, 0);
        checkOutput("reset_adpcm_rst", adpcm_rst, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_underrun", underrun, 0);
        @(negedge clk); #1 rst = 1'b0;

        $display("[TB] basic play of page 2");
        applyStimulus(REG_START, 8'h02);
        applyStimulus(REG_END, 8'h82);
        applyStimulus(REG_GO, 8'h00);
        checkOutput("go_rom_cs", rom_cs, 1);
        checkOutput("go_rom_addr", rom_addr, 16'h0400);
        checkOutput("go_busy", busy, 1);
        waitPlayEnd(12000);

        $display("[TB] stale ok from the slot");
        staleOk = 1'b1;
        applyStimulus(REG_GO, 8'h00);
        waitNibbles(8, 500);
        applyStimulus(REG_STOP, 8'h00);
        staleOk = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] wrap through the top of the region");
        romLatMin = 1; romLatMax = 3; vclkJitter = 2;
        applyStimulus(REG_START, 8'h7F);
        applyStimulus(REG_END, 8'h00);
        applyStimulus(REG_GO, 8'h00);
        checkOutput("wrap_go_addr", rom_addr, 16'hFE00);
        waitPlayEnd(30000);

        $display("[TB] stop mid-play then restart at page 5");
        applyStimulus(REG_START, 8'h02);
        applyStimulus(REG_GO, 8'h00);
        waitNibbles(10, 500);
        applyStimulus(REG_STOP, 8'h00);
        checkOutput("stop_busy", busy, 0);
        checkOutput("stop_rom_cs", rom_cs, 0);
        checkOutput("stop_adpcm_rst", adpcm_rst, 1);
        applyStimulus(REG_START, 8'h05);
        applyStimulus(REG_GO, 8'h00);
        checkOutput("restart_rom_addr", rom_addr, 16'h0A00);
        checkOutput("restart_rom_cs", rom_cs, 1);
        waitNibbles(6, 500);
        applyStimulus(REG_STOP, 8'h00);

        $display("[TB] random short plays");
        for (int r = 0; r < 3; r++) begin
            vclkPeriod = $urandom_range(6, 10);
            applyStimulus(REG_START, 8'($urandom));
            applyStimulus(REG_END, 8'($urandom));
            applyStimulus(REG_GO, 8'h00);
            waitNibbles($urandom_range(20, 100), 3000);
            applyStimulus(REG_STOP, 8'h00);
            repeat ($urandom_range(1, 5)) @(posedge clk);
        end

        $display("[TB] underrun with a slow ROM");
        vclkPeriod = 128; vclkJitter = 0; romLatMin = 200; romLatMax = 200;
        applyStimulus(REG_START, 8'h03);
        applyStimulus(REG_END, 8'h03);
        applyStimulus(REG_GO, 8'h00);
        waitNibbles(6, 2000);
        checkOutput("underrun_set", underrun, 1);
        applyStimulus(REG_GO, 8'h00);
        checkOutput("underrun_cleared", underrun, 0);
        applyStimulus(REG_STOP, 8'h00);

        $display("[TB] asynchronous reset during a fetch");
        vclkPeriod = 8; romLatMin = 3; romLatMax = 3;
        applyStimulus(REG_GO, 8'h00);
        waitNibbles(3, 200);
        begin
            int i;
            i = 0;
            while (!rom_cs && i < 200) begin
                @(posedge clk); #1;
                i++;
            end
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("areset_rom_cs", rom_cs, 0);
        checkOutput("areset_rom_addr", rom_addr, 0);
        checkOutput("areset_adpcm_din", adpcm_din, 0);
        checkOutput("areset_adpcm_rst", adpcm_rst, 1);
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_underrun", underrun, 0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
